bus_xcvr_arbiter: RTL

Round-robin arbiter for the shared 8-bit data bus, which is driven by several 74245-style transceivers, one per source. It drives each transceiver's active-low output enable so that at most one source drives the bus at any time. It enforces a guaranteed dead (all-disabled) turnaround between owners and bounds each owner's tenure when others are waiting. It sits between the bus-request lines of the sources and the N_OE pins of their transceivers.

---
 rtl/bus_xcvr_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_xcvr_arbiter.sv
// Round-robin owner arbiter for a bus shared by several 74245-style transceivers.
// Guarantees a dead turnaround between owners and bounds tenure while others wait.
module bus_xcvr_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 8,
    parameter  int TURN     = 1,
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               CLK,
    input  logic               N_RST,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic [NUM_REQ-1:0] N_OE,
    output logic [IW-1:0]      OWNER,
    output logic               BUSY,
    output logic               PREEMPT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] n_oe_q;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         tcnt_q, tcnt_d;
    logic               busy_q;
    logic               preempt_q, preempt_d;

    logic [IW:0]        sum  [NUM_REQ];
    logic [IW-1:0]      cand [NUM_REQ];
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      owner_next;
    logic               own_req;
    logic               others_req;
    logic               hold_full;

    // cand[gi] is the index examined at search position gi, starting at the pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign sum[gi]  = {1'b0, ptr_q} + (IW+1)'(gi);
            assign cand[gi] = (sum[gi] >= (IW+1)'(NUM_REQ)) ?
                              IW'(sum[gi] - (IW+1)'(NUM_REQ)) : IW'(sum[gi]);
        end
    endgenerate

    // Scan from the far end so the earliest search position overwrites later ones
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ[cand[i]]) begin
                win_found = 1'b1;
                win_idx   = cand[i];
            end
        end
    end

    assign win_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign owner_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    assign own_req    = |(REQ & gnt_q);
    assign others_req = |(REQ & ~gnt_q);
    assign hold_full  = (cnt_q == 8'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        preempt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    cnt_d   = 8'd1;
                end
            end
            S_GRANT: begin
                if (!own_req || (hold_full && others_req)) begin
                    state_d   = S_TURN;
                    gnt_d     = '0;
                    ptr_d     = owner_next;
                    tcnt_d    = 4'd0;
                    preempt_d = own_req;
                end else if (!hold_full) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_TURN: begin
                if (tcnt_q == 4'(TURN - 1)) begin
                    if (win_found) begin
                        state_d = S_GRANT;
                        gnt_d   = win_oh;
                        owner_d = win_idx;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Enables are held in their own register so N_OE drops straight from a flop
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            n_oe_q    <= '1;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            n_oe_q    <= ~gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            busy_q    <= (state_d == S_GRANT);
            preempt_q <= preempt_d;
        end
    end

    assign GNT     = gnt_q;
    assign N_OE    = n_oe_q;
    assign OWNER   = owner_q;
    assign BUSY    = busy_q;
    assign PREEMPT = preempt_q;

endmodule
